// File: rtl/rader7_pkg.sv
// Shared widths, twiddle constants, Rader orderings and FSM states for the
// 7-point inverse DFT (generator 3).
package rader7_pkg;
    localparam int IN_W    = 11;
    localparam int OUT_W   = 15;
    localparam int ACC_W   = 23;
    localparam int LATENCY = 7;

    // 256-scaled cos/sin for nk mod 7 = 1,2,3; 4,5,6 mirror with sin negated
    localparam int COS_C [3] = '{160, -57, -231};
    localparam int SIN_C [3] = '{200, 250, 111};

    // Element 0 first: output order 1,3,2,6,4,5 and feed order 5,4,6,2,3,1
    localparam logic [5:0][2:0] RIDX = {3'd5, 3'd4, 3'd6, 3'd2, 3'd3, 3'd1};
    localparam logic [5:0][2:0] FEED = {3'd1, 3'd3, 3'd2, 3'd6, 3'd4, 3'd5};

    typedef enum logic [1:0] {IDLE, LOAD, RUN, DRAIN} state_e;
endpackage

// File: rtl/rader7_cmul_fir.sv
// 6-tap transposed FIR over one real input path, giving cos- and sin-weighted
// sums from a single shift-add factor block shared by every tap.
module rader7_cmul_fir
    import rader7_pkg::*;
#(
    parameter int COEF_W = 9
) (
    input  logic                    clk_i,
    input  logic signed [IN_W-1:0]  x_i,
    output logic signed [ACC_W-1:0] yc_o,
    output logic signed [ACC_W-1:0] ys_o
);
    // Constant product as a sum of shifted copies; c is always a constant here
    function automatic logic signed [ACC_W-1:0] cmul(input logic signed [IN_W-1:0]   a,
                                                     input logic signed [COEF_W-1:0] c);
        logic signed [ACC_W-1:0] ax;
        logic signed [ACC_W-1:0] r;
        logic        [COEF_W-1:0] mag;
        ax  = ACC_W'(a);
        mag = c[COEF_W-1] ? COEF_W'(-c) : COEF_W'(c);
        r   = '0;
        for (int i = 0; i < COEF_W; i++)
            if (mag[i]) r = r + (ax <<< i);
        return c[COEF_W-1] ? -r : r;
    endfunction

    logic signed [ACC_W-1:0] pc [3];
    logic signed [ACC_W-1:0] ps [3];
    logic signed [ACC_W-1:0] hc [6];
    logic signed [ACC_W-1:0] hs [6];
    logic signed [ACC_W-1:0] zc_q [5];
    logic signed [ACC_W-1:0] zs_q [5];
    logic signed [ACC_W-1:0] yc_q;
    logic signed [ACC_W-1:0] ys_q;

    for (genvar b = 0; b < 3; b++) begin : g_fac
        localparam logic signed [COEF_W-1:0] CC = COEF_W'(COS_C[b]);
        localparam logic signed [COEF_W-1:0] SC = COEF_W'(SIN_C[b]);
        assign pc[b] = cmul(x_i, CC);
        assign ps[b] = cmul(x_i, SC);
    end

    // Tap i carries twiddle W^RIDX[i]; exponents above 3 mirror onto 7-m
    for (genvar i = 0; i < 6; i++) begin : g_tap
        localparam int M = int'(RIDX[i]);
        localparam int B = (M <= 3) ? M - 1 : 6 - M;
        assign hc[i] = pc[B];
        assign hs[i] = (M <= 3) ? ps[B] : -ps[B];
    end

    always_ff @(posedge clk_i) begin
        for (int i = 0; i < 4; i++) begin
            zc_q[i] <= hc[i+1] + zc_q[i+1];
            zs_q[i] <= hs[i+1] + zs_q[i+1];
        end
        zc_q[4] <= hc[5];
        zs_q[4] <= hs[5];
        yc_q    <= hc[0] + zc_q[0];
        ys_q    <= hs[0] + zs_q[0];
    end

    assign yc_o = yc_q;
    assign ys_o = ys_q;
endmodule

// File: rtl/rader7_idft.sv
// 7-point unnormalised inverse DFT: buffers a frame, streams it through two
// Rader FIRs (re/im inputs) and emits x[n] in order 1,3,2,6,4,5,0.
module rader7_idft
    import rader7_pkg::*;
#(
    parameter int COEF_W = 9
) (
    input  logic                    clk,
    input  logic                    reset,
    input  logic                    in_valid,
    output logic                    in_ready,
    input  logic signed [IN_W-1:0]  in_re,
    input  logic signed [IN_W-1:0]  in_im,
    output logic                    out_valid,
    output logic [2:0]              out_idx,
    output logic signed [OUT_W-1:0] out_re,
    output logic signed [OUT_W-1:0] out_im
);
    state_e                  state_q;
    logic [2:0]              cnt_q;
    logic [3:0]              cyc_q;
    logic                    in_ready_q, out_valid_q;
    logic [2:0]              out_idx_q;
    logic signed [OUT_W-1:0] out_re_q, out_im_q;
    logic signed [IN_W-1:0]  smp_re_q [7];
    logic signed [IN_W-1:0]  smp_im_q [7];

    logic                    xfer;
    logic [2:0]              ph;
    logic signed [ACC_W-1:0] yc_re, ys_re, yc_im, ys_im, acc_re, acc_im;
    logic signed [OUT_W-1:0] sum_re, sum_im, re_d, im_d;
    logic [2:0]              idx_d;

    assign xfer = in_valid && in_ready_q;

    // Phase within the 6-cycle Rader cycle; feed index while cyc 0..11
    always_comb begin
        ph = 3'd0;
        if (cyc_q < 4'd6)       ph = cyc_q[2:0];
        else if (cyc_q < 4'd12) ph = 3'(cyc_q - 4'd6);
    end

    rader7_cmul_fir #(.COEF_W(COEF_W)) u_fir_re (
        .clk_i(clk), .x_i(smp_re_q[FEED[ph]]), .yc_o(yc_re), .ys_o(ys_re)
    );
    rader7_cmul_fir #(.COEF_W(COEF_W)) u_fir_im (
        .clk_i(clk), .x_i(smp_im_q[FEED[ph]]), .yc_o(yc_im), .ys_o(ys_im)
    );

    always_comb begin
        acc_re = yc_re - ys_im;
        acc_im = ys_re + yc_im;
        sum_re = '0;
        sum_im = '0;
        for (int k = 0; k < 7; k++) begin
            sum_re = sum_re + OUT_W'(smp_re_q[k]);
            sum_im = sum_im + OUT_W'(smp_im_q[k]);
        end
        if (cyc_q == 4'd12) begin
            idx_d = 3'd0;
            re_d  = sum_re;
            im_d  = sum_im;
        end else begin
            idx_d = RIDX[ph];
            re_d  = OUT_W'(acc_re >>> 8) + OUT_W'(smp_re_q[0]);
            im_d  = OUT_W'(acc_im >>> 8) + OUT_W'(smp_im_q[0]);
        end
    end

    // Buffer holds a frame by arrival order; only written while accepting
    always_ff @(posedge clk) begin
        if (xfer) begin
            smp_re_q[cnt_q] <= in_re;
            smp_im_q[cnt_q] <= in_im;
        end
    end

    always_ff @(posedge clk) begin
        if (!reset) begin
            state_q     <= IDLE;
            cnt_q       <= '0;
            cyc_q       <= '0;
            in_ready_q  <= 1'b0;
            out_valid_q <= 1'b0;
            out_idx_q   <= '0;
            out_re_q    <= '0;
            out_im_q    <= '0;
        end else begin
            out_valid_q <= 1'b0;
            unique case (state_q)
                IDLE, LOAD: begin
                    in_ready_q <= 1'b1;
                    if (xfer) begin
                        if (cnt_q == 3'd6) begin
                            state_q    <= RUN;
                            cnt_q      <= '0;
                            cyc_q      <= '0;
                            in_ready_q <= 1'b0;
                        end else begin
                            state_q <= LOAD;
                            cnt_q   <= cnt_q + 3'd1;
                        end
                    end
                end
                RUN, DRAIN: begin
                    cyc_q <= cyc_q + 4'd1;
                    if (cyc_q == 4'd10) state_q <= DRAIN;
                    // cyc 6..11 carry FIR results, 12 the exact DC sum
                    if (cyc_q >= 4'd6 && cyc_q <= 4'd12) begin
                        out_valid_q <= 1'b1;
                        out_idx_q   <= idx_d;
                        out_re_q    <= re_d;
                        out_im_q    <= im_d;
                    end
                    if (cyc_q == 4'd13) begin
                        state_q    <= IDLE;
                        cyc_q      <= '0;
                        in_ready_q <= 1'b1;
                    end
                end
                default: state_q <= IDLE;
            endcase
        end
    end

    assign in_ready  = in_ready_q;
    assign out_valid = out_valid_q;
    assign out_idx   = out_idx_q;
    assign out_re    = out_re_q;
    assign out_im    = out_im_q;
endmodule

// File: tb/tb_rader7_idft.sv
// Self-checking bench for rader7_idft: table vectors, stall, mid-frame reset
// and back-to-back random frames against a direct-DFT reference.
module tb_rader7_idft;
    import rader7_pkg::*;

    logic               clk = 1'b0;
    logic               reset, in_valid, in_ready, out_valid;
    logic signed [10:0] in_re, in_im;
    logic [2:0]         out_idx;
    logic signed [14:0] out_re, out_im;

    always #5 clk = ~clk;

    rader7_idft #(.COEF_W(9)) dut (
        .clk(clk), .reset(reset), .in_valid(in_valid), .in_ready(in_ready),
        .in_re(in_re), .in_im(in_im), .out_valid(out_valid), .out_idx(out_idx),
        .out_re(out_re), .out_im(out_im)
    );

    typedef struct { int idx; int re; int im; } exp_t;
    typedef struct { int xr[7]; int xi[7]; int er[7]; int ei[7]; } vec_t;

    localparam int ORD [7] = '{1, 3, 2, 6, 4, 5, 0};
    localparam int CM  [7] = '{256, 160, -57, -231, -231, -57, 160};
    localparam int SM  [7] = '{0, 200, 250, 111, -111, -250, -200};

    exp_t sbq[$];
    exp_t last_e;
    vec_t vt [4];
    int   errors = 0, checks = 0;
    int   cyc = 0, nout = 0, first_cyc = 0, last_c0 = 0;
    bit   prev_valid = 1'b0;

    always @(posedge clk) cyc <= cyc + 1;

    always @(negedge clk) begin
        exp_t e;
        if (out_valid === 1'b1) begin
            if (!prev_valid) first_cyc = cyc;
            if (out_idx == 3'd0) last_c0 = cyc;
            nout++;
            checks++;
            if (sbq.size() == 0) begin
                errors++;
                $display("FAIL unexpected_out got idx=%0d re=%0d im=%0d exp=none", out_idx, out_re, out_im);
            end else begin
                e = sbq.pop_front();
                last_e = e;
                if (out_idx !== 3'(e.idx) || out_re !== 15'(e.re) || out_im !== 15'(e.im)) begin
                    errors++;
                    $display("FAIL out_sample got idx=%0d re=%0d im=%0d exp idx=%0d re=%0d im=%0d",
                             out_idx, out_re, out_im, e.idx, e.re, e.im);
                end
            end
        end
        prev_valid = (out_valid === 1'b1);
    end

    task automatic chk(input string nm, input int act, input int exp);
        checks++;
        if (act != exp) begin
            errors++;
            $display("FAIL %s got=%0d exp=%0d", nm, act, exp);
        end
    endtask

    task automatic push_exp(input int er[7], input int ei[7]);
        exp_t e;
        for (int j = 0; j < 7; j++) begin
            e.idx = ORD[j]; e.re = er[j]; e.im = ei[j];
            sbq.push_back(e);
        end
    endtask

    // Direct inverse DFT with the same floor-shift rounding rule
    task automatic push_model(input int xr[7], input int xi[7]);
        int er[7], ei[7];
        for (int j = 0; j < 7; j++) begin
            int n, ar, ai, m;
            n = ORD[j]; ar = 0; ai = 0;
            if (n == 0) begin
                for (int k = 0; k < 7; k++) begin ar += xr[k]; ai += xi[k]; end
                er[j] = ar; ei[j] = ai;
            end else begin
                for (int k = 1; k < 7; k++) begin
                    m = (n * k) % 7;
                    ar += xr[k] * CM[m] - xi[k] * SM[m];
                    ai += xr[k] * SM[m] + xi[k] * CM[m];
                end
                er[j] = (ar >>> 8) + xr[0];
                ei[j] = (ai >>> 8) + xi[0];
            end
        end
        push_exp(er, ei);
    endtask

    // Called and returns at posedge+1; leaves in_valid as last driven
    task automatic send_frame(input int xr[7], input int xi[7], input int stall_at,
                              input int stall_len, output int t1, output int t7);
        int k = 0, st = stall_len, guard = 0;
        bit rdy;
        t1 = 0; t7 = 0;
        while (k < 7) begin
            if (k == stall_at && st > 0) begin
                in_valid = 1'b0; st--;
            end else begin
                in_valid = 1'b1; in_re = 11'(xr[k]); in_im = 11'(xi[k]);
            end
            @(negedge clk); rdy = in_ready;
            @(posedge clk); #1;
            if (in_valid && rdy) begin
                if (k == 0) t1 = cyc;
                k++;
                if (k == 7) t7 = cyc;
            end
            guard++;
            if (guard > 200) begin
                chk("send_timeout", k, 7);
                break;
            end
        end
    endtask

    task automatic wait_drain();
        int n = 0;
        while (sbq.size() != 0 && n < 100) begin @(negedge clk); n++; end
        chk("drain_pending", sbq.size(), 0);
        sbq.delete();
        repeat (3) @(posedge clk);
        #1;
    endtask

    function automatic int rnd11();
        return int'($urandom_range(2047)) - 1024;
    endfunction

    initial begin
        #200000;
        $display("FAIL watchdog got=timeout exp=finish");
        $fatal(1, "watchdog");
    end

    initial begin
        int t1, t7, n0, r[7], q[7];
        reset = 1'b0; in_valid = 1'b0; in_re = '0; in_im = '0;

        vt[0].xr = '{100, 0, 0, 0, 0, 0, 0};   vt[0].xi = '{0, 0, 0, 0, 0, 0, 0};
        vt[0].er = '{100, 100, 100, 100, 100, 100, 100};
        vt[0].ei = '{0, 0, 0, 0, 0, 0, 0};
        vt[1].xr = '{0, 256, 0, 0, 0, 0, 0};   vt[1].xi = '{0, 0, 0, 0, 0, 0, 0};
        vt[1].er = '{160, -231, -57, 160, -231, -57, 256};
        vt[1].ei = '{200, 111, 250, -200, -111, -250, 0};
        vt[2].xr = '{10, 10, 10, 10, 10, 10, 10}; vt[2].xi = '{0, 0, 0, 0, 0, 0, 0};
        vt[2].er = '{0, 0, 0, 0, 0, 0, 70};
        vt[2].ei = '{0, 0, 0, 0, 0, 0, 0};
        vt[3].xr = '{0, 1, 0, 0, 0, 0, 0};     vt[3].xi = '{0, 0, 0, 0, 0, 0, 0};
        vt[3].er = '{0, -1, -1, 0, -1, -1, 1};
        vt[3].ei = '{0, 0, 0, -1, -1, -1, 0};

        repeat (3) @(posedge clk);
        @(negedge clk);
        chk("rst_out_valid", int'(out_valid), 0);
        chk("rst_out_idx", int'(out_idx), 0);
        chk("rst_out_re", int'(out_re), 0);
        chk("rst_out_im", int'(out_im), 0);
        chk("rst_in_ready", int'(in_ready), 0);
        @(posedge clk); #1 reset = 1'b1;
        @(posedge clk); @(negedge clk);
        chk("ready_after_release", int'(in_ready), 1);
        @(posedge clk); #1;

        for (int v = 0; v < 4; v++) begin
            push_exp(vt[v].er, vt[v].ei);
            send_frame(vt[v].xr, vt[v].xi, -1, 0, t1, t7);
            in_valid = 1'b0;
            wait_drain();
            chk($sformatf("latency_vec%0d", v), first_cyc - t7, LATENCY);
        end

        for (int i = 0; i < 3; i++) begin
            @(negedge clk);
            chk("hold_valid", int'(out_valid), 0);
            chk("hold_idx", int'(out_idx), last_e.idx);
            chk("hold_re", int'(out_re), last_e.re);
            chk("hold_im", int'(out_im), last_e.im);
        end
        @(posedge clk); #1;

        push_exp(vt[0].er, vt[0].ei);
        send_frame(vt[0].xr, vt[0].xi, 3, 3, t1, t7);
        in_valid = 1'b0;
        wait_drain();
        chk("latency_stall", first_cyc - t7, LATENCY);

        for (int k = 0; k < 7; k++) begin r[k] = rnd11(); q[k] = rnd11(); end
        send_frame(r, q, -1, 0, t1, t7);
        in_valid = 1'b0;
        repeat (3) @(posedge clk);
        #1 reset = 1'b0;
        @(posedge clk); #1 reset = 1'b1;
        n0 = nout;
        repeat (25) @(negedge clk);
        chk("no_out_after_reset", nout - n0, 0);
        @(posedge clk); #1;

        for (int k = 0; k < 7; k++) begin r[k] = rnd11(); q[k] = rnd11(); end
        push_model(r, q);
        send_frame(r, q, -1, 0, t1, t7);
        in_valid = 1'b0;
        wait_drain();
        chk("latency_post_reset", first_cyc - t7, LATENCY);

        for (int f = 0; f < 20; f++) begin
            for (int k = 0; k < 7; k++) begin r[k] = rnd11(); q[k] = rnd11(); end
            push_model(r, q);
            send_frame(r, q, -1, 0, t1, t7);
            if (f > 0) chk("b2b_accept_gap", t1 - last_c0, 2);
        end
        in_valid = 1'b0;
        wait_drain();

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end
endmodule
